// File: rtl/alu_pkg.sv
// alu_pkg: funct codes, FSM state encoding and R-type field layout for alu_issue_ctrl
package alu_pkg;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int FN_LSB = 0;
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  function automatic logic legal(input logic [31:0] w);
    logic [5:0] f;
    f = w[FN_LSB +: 6];
    return w[OP_LSB +: 6] == 6'd0 &&
           (f == FN_AND || f == FN_OR || f == FN_ADD || f == FN_SUB || f == FN_SLT);
  endfunction
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: instruction handshake, ALU drive/return and completion signals; err exists only with ALU_ISSUE_TRAP_EN
interface alu_issue_ctrl_if;
  logic        instr_valid, instr_ready, done;
  logic [31:0] instr, alu_a, alu_b, alu_result, done_data;
  logic [5:0]  alu_funct;
  logic [4:0]  done_rd;
`ifdef ALU_ISSUE_TRAP_EN
  logic        err;
  modport slave (input instr_valid, instr, alu_result,
                 output instr_ready, alu_a, alu_b, alu_funct, done, done_rd, done_data, err);
  modport master (output instr_valid, instr, alu_result,
                  input instr_ready, alu_a, alu_b, alu_funct, done, done_rd, done_data, err);
`else
  modport slave (input instr_valid, instr, alu_result,
                 output instr_ready, alu_a, alu_b, alu_funct, done, done_rd, done_data);
  modport master (output instr_valid, instr, alu_result,
                  input instr_ready, alu_a, alu_b, alu_funct, done, done_rd, done_data);
`endif
endinterface

// File: rtl/alu_regfile.sv
// alu_regfile: 32x32 register file, r0 hardwired to zero, two operand reads, one debug read, one write port
module alu_regfile #(
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  input  logic [4:0]  rdbg,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [31:0] dbg
);
  logic [31:0] regs [NUM_REGS];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  assign a   = ra   == 5'd0 ? '0 : regs[ra];
  assign b   = rb   == 5'd0 ? '0 : regs[rb];
  assign dbg = rdbg == 5'd0 ? '0 : regs[rdbg];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: IDLE->EXEC->WB issue controller for R-type ALU ops; define ALU_ISSUE_TRAP_EN to trap illegal words
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_issue_ctrl_if.slave    bus,
  input  logic               pre_we,
  input  logic [4:0]         pre_waddr,
  input  logic [31:0]        pre_wdata,
  input  logic [4:0]         dbg_raddr,
  output logic [31:0]        dbg_rdata
);
  state_t      state;
  logic [31:0] instr_q, res_q, ra_data, rb_data, wdata;
  logic [4:0]  rd, waddr;
  logic        trap, trap_q, exec, wb, we, accept, unused_bits;
  assign rd     = instr_q[RD_LSB +: 5];
  assign exec   = state == EXEC;
  assign wb     = state == WB;
  assign accept = bus.instr_valid && bus.instr_ready;
`ifdef ALU_ISSUE_TRAP_EN
  assign trap        = !legal(instr_q);
  assign bus.err     = wb && trap_q;
  assign unused_bits = ^instr_q[10:6];
`else
  assign trap        = 1'b0;
  assign unused_bits = ^{instr_q[31:26], instr_q[10:6]};
`endif
  assign bus.instr_ready = state == IDLE && rst_n;
  assign bus.alu_a       = exec ? ra_data : '0;
  assign bus.alu_b       = exec ? rb_data : '0;
  assign bus.alu_funct   = exec ? instr_q[FN_LSB +: 6] : '0;
  assign bus.done        = wb;
  assign bus.done_rd     = wb ? rd : '0;
  assign bus.done_data   = wb && !trap_q ? res_q : '0;
  // writeback owns the write port in WB; preload only lands while idle
  assign we    = wb ? !trap_q && rd != 5'd0 : state == IDLE && pre_we;
  assign waddr = wb ? rd : pre_waddr;
  assign wdata = wb ? res_q : pre_wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      instr_q <= '0;
      res_q   <= '0;
      trap_q  <= 1'b0;
    end else begin
      state <= state == IDLE ? (accept ? EXEC : IDLE) : exec ? WB : IDLE;
      if (accept) instr_q <= bus.instr;
      if (exec) begin
        res_q  <= bus.alu_result;
        trap_q <= trap;
      end
    end
  alu_regfile #(.NUM_REGS(NUM_REGS)) u_regs (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .ra    (instr_q[RS_LSB +: 5]),
    .rb    (instr_q[RT_LSB +: 5]),
    .rdbg  (dbg_raddr),
    .a     (ra_data),
    .b     (rb_data),
    .dbg   (dbg_rdata)
  );
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed checks of issue timing, writeback, preload/debug ports, reset abort and optional trapping
module tb_alu_issue_ctrl;
  logic clk, rst_n, pre_we;
  logic [4:0] pre_waddr, dbg_raddr;
  logic [31:0] pre_wdata, dbg_rdata;
  int checks = 0, fails = 0;
  alu_issue_ctrl_if bus();
  alu_issue_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .pre_we    (pre_we),
    .pre_waddr (pre_waddr),
    .pre_wdata (pre_wdata),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // reference ALU sitting outside the block; NOR covers the non-core funct
  always_comb
    case (bus.alu_funct)
      6'b100100: bus.alu_result = bus.alu_a & bus.alu_b;
      6'b100101: bus.alu_result = bus.alu_a | bus.alu_b;
      6'b100000: bus.alu_result = bus.alu_a + bus.alu_b;
      6'b100010: bus.alu_result = bus.alu_a - bus.alu_b;
      6'b101010: bus.alu_result = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      6'b100111: bus.alu_result = ~(bus.alu_a | bus.alu_b);
      default:   bus.alu_result = 32'hDEAD_BEEF;
    endcase

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic dbg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    dbg_raddr = a;
    #1 check(tag, dbg_rdata, exp);
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d, input logic [31:0] old);
    pre_we = 1'b1; pre_waddr = a; pre_wdata = d; dbg_raddr = a;
    #1 check("dbg_prewrite", dbg_rdata, old);
    @(negedge clk);
    pre_we = 1'b0;
    #1 check("dbg_postwrite", dbg_rdata, d);
  endtask

  // called just before the clock edge that accepts w; ign drives a preload through EXEC/WB
  task automatic run(input logic [31:0] w, input logic [31:0] ea, input logic [31:0] eb,
                     input logic [5:0] fn, input logic [4:0] rd, input logic [31:0] data,
                     input logic er, input logic ign);
    check("idle_ready", bus.instr_ready, 1);
    bus.instr_valid = 1'b1; bus.instr = w;
    @(negedge clk);
    bus.instr_valid = 1'b0; bus.instr = 32'hFFFF_FFFF;
    pre_we = ign; pre_waddr = 5'd6; pre_wdata = 32'd99;
    check("exec_ready", bus.instr_ready, 0);
    check("exec_done", bus.done, 0);
    check("exec_a", bus.alu_a, ea);
    check("exec_b", bus.alu_b, eb);
    check("exec_funct", bus.alu_funct, fn);
    @(negedge clk);
    check("wb_done", bus.done, 1);
    check("wb_rd", bus.done_rd, rd);
    check("wb_data", bus.done_data, data);
    check("wb_funct", bus.alu_funct, 0);
`ifdef ALU_ISSUE_TRAP_EN
    check("wb_err", bus.err, er);
`else
    check("wb_err_absent", er, 0);
`endif
    @(negedge clk);
    pre_we = 1'b0;
    check("idle_done", bus.done, 0);
    check("idle_rd", bus.done_rd, 0);
    check("idle_data", bus.done_data, 0);
  endtask

  logic [31:0] words [4];
  logic [31:0] exp_d [3];
  int acc [3];
  int k, j;
  initial begin
    rst_n = 1'b0; pre_we = 1'b0; pre_waddr = '0; pre_wdata = '0; dbg_raddr = '0;
    bus.instr_valid = 1'b0; bus.instr = '0;
    @(negedge clk); @(negedge clk);
    check("rst_ready", bus.instr_ready, 0);
    check("rst_done", bus.done, 0);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_data", bus.done_data, 0);
    rst_n = 1'b1;
    #1 check("rel_ready", bus.instr_ready, 1);
    @(negedge clk);
    preload(5'd1, 32'd5, 32'd0);
    @(negedge clk);
    preload(5'd2, 32'd3, 32'd0);
    @(negedge clk);
    run(32'h0022_1820, 32'd5, 32'd3, 6'b100000, 5'd3, 32'd8, 1'b0, 1'b0);
    dbg("add_r3", 5'd3, 32'd8);
    @(negedge clk);
    run(32'h0022_1822, 32'd5, 32'd3, 6'b100010, 5'd3, 32'd2, 1'b0, 1'b0);
    dbg("sub_r3", 5'd3, 32'd2);
    @(negedge clk);
    run(32'h0022_0020, 32'd5, 32'd3, 6'b100000, 5'd0, 32'd8, 1'b0, 1'b0);
    dbg("r0_zero", 5'd0, 32'd0);
    @(negedge clk);
`ifdef ALU_ISSUE_TRAP_EN
    run(32'h0022_1827, 32'd5, 32'd3, 6'b100111, 5'd3, 32'd0, 1'b1, 1'b0);
    dbg("trap_r3", 5'd3, 32'd2);
    @(negedge clk);
    run(32'h0422_1820, 32'd5, 32'd3, 6'b100000, 5'd3, 32'd0, 1'b1, 1'b0);
    dbg("trap_op_r3", 5'd3, 32'd2);
`else
    run(32'h0022_1827, 32'd5, 32'd3, 6'b100111, 5'd3, 32'hFFFF_FFF8, 1'b0, 1'b0);
    dbg("nor_r3", 5'd3, 32'hFFFF_FFF8);
`endif
    @(negedge clk);
    pre_we = 1'b1; pre_waddr = 5'd4; pre_wdata = 32'd10;
    run(32'h0081_2820, 32'd10, 32'd5, 6'b100000, 5'd5, 32'd15, 1'b0, 1'b1);
    dbg("coinc_r5", 5'd5, 32'd15);
    dbg("coinc_r4", 5'd4, 32'd10);
    dbg("ignored_r6", 5'd6, 32'd0);
    @(negedge clk);
    words = '{32'h0022_1820, 32'h0022_1822, 32'h0022_1824, 32'h0000_0000};
    exp_d = '{32'd8, 32'd2, 32'd1};
    acc = '{-1, -1, -1};
    k = 0; j = 0;
    bus.instr_valid = 1'b1;
    for (int c = 0; c < 9; c++) begin
      bus.instr = words[k];
      if (bus.done) begin
        check("b2b_data", bus.done_data, exp_d[j]);
        j++;
      end
      if (bus.instr_ready) begin
        acc[k] = c;
        k++;
      end
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    check("b2b_accepts", k, 3);
    check("b2b_dones", j, 3);
    check("b2b_acc1", acc[1] - acc[0], 3);
    check("b2b_acc2", acc[2] - acc[1], 3);
    bus.instr_valid = 1'b1; bus.instr = 32'h0022_1820;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    check("abort_in_exec", bus.alu_funct, 6'b100000);
    rst_n = 1'b0;
    #1 check("abort_done", bus.done, 0);
    check("abort_ready", bus.instr_ready, 0);
    check("abort_alu_a", bus.alu_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("abort_rel_ready", bus.instr_ready, 1);
    dbg("abort_r1", 5'd1, 32'd0);
    dbg("abort_r5", 5'd5, 32'd0);
    @(negedge clk);
    check("abort_no_done", bus.done, 0);
    dbg("abort_r3", 5'd3, 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
